alu_sequencer: RTL and testbench

- Initiator for the single-cycle ALU interface: accepts operation requests over a valid/ready handshake and maps them onto the ALU's 3-bit opcode encoding.
- Drives the ALU operands and opcode, captures `result`/`zero`, and returns them over a valid/ready response channel.
- Adds a multi-cycle unsigned multiply built as a 32-step shift-add loop on the ALU's add operation.
- Sits between the issue logic and an external `alu` instance; one operation is in flight at a time.

---
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one request at a time to an external single-cycle ALU,
// adds a WIDTH-step shift-add multiply on top of the ALU adder, and returns
// results over a valid/ready response channel.
module alu_sequencer #(
  parameter int WIDTH      = 32,
  parameter int ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    count;

  logic             accept;
  logic             is_alu_op;
  logic             is_mul_op;
  logic             last_iter;
  logic [WIDTH-1:0] acc_next;

  assign accept    = req_valid && req_ready;
  assign is_alu_op = (req_op <= 3'd4);
  assign is_mul_op = (req_op == 3'd5) && (ENABLE_MUL != 0);
  assign last_iter = (count == CW'(WIDTH - 1));
  // Accumulator value after the current multiply step; the ALU adds mcand to acc.
  assign acc_next  = mplier[0] ? alu_result : acc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (is_alu_op)      state_nxt = EXEC;
        else if (is_mul_op) state_nxt = MUL;
        else                state_nxt = RESP;
      end
      EXEC:    state_nxt = RESP;
      MUL:     if (last_iter) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and ALU drive outputs
  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = 3'b000;
    case (state)
      EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (op_q)
          3'd0:    alu_opcode = 3'b000;
          3'd1:    alu_opcode = 3'b001;
          3'd2:    alu_opcode = 3'b010;
          3'd3:    alu_opcode = 3'b011;
          3'd4:    alu_opcode = 3'b101;
          default: alu_opcode = 3'b000;
        endcase
      end
      MUL: begin
        alu_a      = acc;
        alu_b      = mcand;
        alu_opcode = 3'b000;
      end
      default: ;
    endcase
  end

  // Operand latch, multiply datapath and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= req_op;
          a_q  <= req_a;
          b_q  <= req_b;
          if (is_mul_op) begin
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            count  <= '0;
          end else if (!is_alu_op) begin
            rsp_err    <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // Response is taken from acc_next so the final step's add is included.
          if (last_iter) begin
            rsp_result <= acc_next;
            rsp_zero   <= (acc_next == '0);
            rsp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU, scoreboard of expected
// responses, per-scenario tasks.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_opcode;
  logic        alu_zero;

  logic        req_valid2, req_ready2;
  logic [2:0]  req_op2;
  logic [31:0] req_a2, req_b2;
  logic        rsp_valid2, rsp_ready2;
  logic [31:0] rsp_result2;
  logic        rsp_zero2, rsp_err2;
  logic [31:0] alu_a2, alu_b2, alu_result2;
  logic [2:0]  alu_opcode2;
  logic        alu_zero2;

  int checks = 0;
  int failures = 0;
  logic [33:0] sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    case (opc)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result  = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_zero    = (alu_result == 32'd0);
  assign alu_result2 = alu_fn(alu_opcode2, alu_a2, alu_b2);
  assign alu_zero2   = (alu_result2 == 32'd0);

  alu_sequencer #(.WIDTH(32), .ENABLE_MUL(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_sequencer #(.WIDTH(32), .ENABLE_MUL(0)) dut_nomul (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op2), .req_a(req_a2), .req_b(req_b2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_result(rsp_result2), .rsp_zero(rsp_zero2), .rsp_err(rsp_err2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2), .alu_result(alu_result2), .alu_zero(alu_zero2)
  );

  // Reference: {err, zero, result}
  function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic e;
    r = '0;
    e = 1'b0;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = (a < b) ? 32'd1 : 32'd0;
      3'd5:    r = a * b;
      default: e = 1'b1;
    endcase
    return {e, (!e && r == 32'd0), r};
  endfunction

  function automatic logic [2:0] exp_opc(input logic [2:0] op);
    case (op)
      3'd4:    return 3'b101;
      3'd5:    return 3'b000;
      default: return op;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (op <= 3'd4) return 2;
    if (op == 3'd5) return 33;
    return 1;
  endfunction

  // Scoreboard: compare every completed response against the oldest expectation
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got err=%b zero=%b result=%h with nothing pending", rsp_err, rsp_zero, rsp_result);
      end else begin
        logic [33:0] exp;
        exp = sb_q.pop_front();
        if ({rsp_err, rsp_zero, rsp_result} !== exp) begin
          failures++;
          $display("FAIL rsp_data got err=%b zero=%b result=%h expected err=%b zero=%b result=%h",
                   rsp_err, rsp_zero, rsp_result, exp[33], exp[32], exp[31:0]);
        end
      end
    end
  end

  // Issue one request (called at posedge+#1), check ALU drive and latency
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit ok;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout op=%0d req_ready=%b expected 1", op, req_ready);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      checks++;
      if (alu_opcode !== exp_opc(op)) begin
        failures++;
        $display("FAIL alu_opcode op=%0d cycle=%0d got %b expected %b", op, lat, alu_opcode, exp_opc(op));
      end
      if (lat == 1) begin
        checks++;
        if (alu_a !== ((op == 3'd5) ? 32'd0 : a) || alu_b !== ((op == 3'd5) ? a : b)) begin
          failures++;
          $display("FAIL alu_operands op=%0d got a=%h b=%h", op, alu_a, alu_b);
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!ok || lat != exp_lat(op)) begin
      failures++;
      $display("FAIL latency op=%0d got %0d expected %0d (seen=%b)", op, lat, exp_lat(op), ok);
    end
    if (rsp_ready) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rsp_one_cycle got rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd1; req_b = 32'd1;
    req_valid2 = 1'b0; req_op2 = 3'd0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b rdy=%b res=%h z=%b e=%b expected 0 1 0 0 0",
               rsp_valid, req_ready, rsp_result, rsp_zero, rsp_err);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_opcode !== 3'b000) begin
      failures++;
      $display("FAIL reset_alu_drive got a=%h b=%h opc=%b expected zeros", alu_a, alu_b, alu_opcode);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_accept got rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_alu_ops();
    run_op(3'd0, 32'd5, 32'd7);
    run_op(3'd1, 32'h10, 32'h10);
    run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op(3'd3, 32'h8000_0000, 32'h0000_0001);
    run_op(3'd4, 32'd3, 32'd9);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd1);
    run_op(3'd4, 32'd9, 32'd9);
  endtask

  task automatic test_mul();
    run_op(3'd5, 32'd3, 32'd7);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd5, 32'h1234, 32'd0);
    run_op(3'd5, 32'h0001_0003, 32'h8001_0005);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    run_op(3'd3, 32'hF0, 32'h0F);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd100; req_b = 32'd200;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d got v=%b res=%h rdy=%b expected 1 ff 0",
                 i, rsp_valid, rsp_result, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release got rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_no_accept got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_illegal();
    run_op(3'd6, 32'd1, 32'd2);
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // MUL code on an instance built without the multiplier
    req_valid2 = 1'b1; req_op2 = 3'd5; req_a2 = 32'd3; req_b2 = 32'd7;
    @(negedge clk);
    checks++;
    if (req_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL nomul_ready got %b expected 1", req_ready2);
    end
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_err2 !== 1'b1 || rsp_result2 !== 32'd0 || rsp_zero2 !== 1'b0) begin
      failures++;
      $display("FAIL nomul_mul_illegal got v=%b e=%b res=%h z=%b expected 1 1 0 0",
               rsp_valid2, rsp_err2, rsp_result2, rsp_zero2);
    end
    @(posedge clk); #1;
    req_valid2 = 1'b1; req_op2 = 3'd0; req_a2 = 32'd2; req_b2 = 32'd3;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_err2 !== 1'b0 || rsp_result2 !== 32'd5) begin
      failures++;
      $display("FAIL nomul_add got v=%b e=%b res=%h expected 1 0 5", rsp_valid2, rsp_err2, rsp_result2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    req_valid = 1'b1; req_op = 3'd5; req_a = 32'd123; req_b = 32'd456;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (alu_opcode !== 3'b000 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_mul_state got opc=%b v=%b rdy=%b expected 000 0 0", alu_opcode, rsp_valid, req_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_opcode !== 3'b000) begin
      failures++;
      $display("FAIL mid_mul_reset got v=%b rdy=%b res=%h z=%b e=%b a=%h b=%h opc=%b",
               rsp_valid, req_ready, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_mul_stale got rsp_valid=%b expected 0", rsp_valid);
    end
    run_op(3'd0, 32'd1, 32'd1);
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      run_op(op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_mul();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
